// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared state type, word size and line slot positioning for the cache fill unit
package cache_fill_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} fill_state_t;

    localparam int WORD_BYTES = 4;

    function automatic int slot_hi(input int k, input int blocksize);
        return (blocksize - k) * 32 - 1;
    endfunction

endpackage

// File: rtl/cache_fill_unit_line_buffer.sv
// fill_line_buffer: blocksize x 32 line register, word offset 0 placed in the top slot of the packed line
module fill_line_buffer
    import cache_fill_pkg::*;
#(
    parameter  int blocksize = 4,
    localparam int bo_bits   = $clog2(blocksize)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_we,
    input  logic [bo_bits-1:0]        i_idx,
    input  logic [31:0]               i_wdata,
    output logic [blocksize*32-1:0]   o_line
);

    logic [31:0] r_words [blocksize];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < blocksize; k++) r_words[k] <= '0;
        end else if (i_we) begin
            r_words[i_idx] <= i_wdata;
        end
    end

    for (genvar k = 0; k < blocksize; k++) begin : g_slot
        assign o_line[slot_hi(k, blocksize) -: 32] = r_words[k];
    end

endmodule

// File: rtl/cache_fill_unit.sv
// cache_fill_unit: turns cache line reads into word bursts and write-through stores into single bus writes
module cache_fill_unit
    import cache_fill_pkg::*;
#(
    parameter  int blocksize = 4,
    localparam int bo_bits   = $clog2(blocksize)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memread,
    input  logic                    memwrite,
    input  logic [31:0]             a,
    input  logic [31:0]             wd,
    output logic [blocksize*32-1:0] memdata,
    output logic                    memready,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [31:0]             bus_addr,
    output logic [31:0]             bus_wdata,
    input  logic [31:0]             bus_rdata,
    input  logic                    bus_ack
);

    fill_state_t        r_state, w_next;
    logic [bo_bits-1:0] r_cnt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               w_fill_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        memready  = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        w_fill_we = 1'b0;
        case (r_state)
            IDLE:  w_next = memwrite ? WRITE : memread ? READ : IDLE;
            READ: begin
                bus_req   = 1'b1;
                bus_addr  = {r_addr[31:bo_bits+2], r_cnt, 2'b00};
                w_fill_we = bus_ack;
                if (bus_ack && (&r_cnt)) w_next = DONE;
            end
            WRITE: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = r_addr;
                if (bus_ack) w_next = DONE;
            end
            DONE: begin
                memready = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Address and data are captured once at entry so the cache may change them mid-transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && (memread || memwrite)) begin
            r_cnt   <= '0;
            r_addr  <= a & ~32'(WORD_BYTES - 1);
            r_wdata <= wd;
        end else if (w_fill_we) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus_wdata = r_wdata;

    fill_line_buffer #(.blocksize(blocksize)) u_line (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_fill_we),
        .i_idx   (r_cnt),
        .i_wdata (bus_rdata),
        .o_line  (memdata)
    );

endmodule

// File: tb/tb_cache_fill_unit.sv
// tb_cache_fill_unit: directed tests of line fills, write-through, priority, reset abort and stray acks
module tb_cache_fill_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         memread, memwrite;
    logic [31:0]  a, wd;
    logic [127:0] memdata;
    logic         memready, bus_req, bus_we;
    logic [31:0]  bus_addr, bus_wdata;
    logic [31:0]  bus_rdata = '0;
    logic         bus_ack = 1'b0;

    int          n_chk = 0, n_fail = 0;
    int          ack_delay = 0, wait_cnt = 0, rdy_cnt = 0, stab_err = 0;
    logic        stray = 1'b0;
    logic [31:0] rd_base = 32'hA0;
    logic [31:0] addr_q [$];
    logic        prev_pend = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wd;

    cache_fill_unit #(.blocksize(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .a         (a),
        .wd        (wd),
        .memdata   (memdata),
        .memready  (memready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    // Bus slave: acks after ack_delay wait cycles, data = rd_base + word offset, logs acked addresses.
    always @(negedge clk) begin
        if (memready) rdy_cnt++;
        if (bus_req && prev_pend && (bus_addr !== prev_addr || bus_we !== prev_we || bus_wdata !== prev_wd))
            stab_err++;
        if (bus_req && wait_cnt >= ack_delay) begin
            bus_ack   = 1'b1;
            bus_rdata = rd_base + {30'd0, bus_addr[3:2]};
            addr_q.push_back(bus_addr);
            wait_cnt  = 0;
            prev_pend = 1'b0;
        end else if (bus_req) begin
            bus_ack   = stray;
            wait_cnt++;
            prev_pend = 1'b1;
            prev_addr = bus_addr;
            prev_we   = bus_we;
            prev_wd   = bus_wdata;
        end else begin
            bus_ack   = stray;
            wait_cnt  = 0;
            prev_pend = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!memready && n < 50);
    endtask

    task automatic test_reset();
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; a = '0; wd = '0;
        step(); step();
        n_chk++;
        if ({memready, bus_req, bus_we, bus_addr, bus_wdata} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b req=%b we=%b addr=%h wd=%h, expected all 0", memready, bus_req, bus_we, bus_addr, bus_wdata);
        end
        n_chk++;
        if (memdata !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_memdata: got %h expected 0", memdata);
        end
        reset = 1'b0;
        step();
        n_chk++;
        if (bus_req !== 1'b0 || memready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got req=%b rdy=%b expected 0 0", bus_req, memready);
        end
    endtask

    task automatic test_read_burst();
        int n;
        int r0;
        addr_q.delete(); rd_base = 32'hA0; ack_delay = 0; r0 = rdy_cnt;
        memread = 1'b1; a = 32'h0000_1238;
        wait_ready(n);
        memread = 1'b0;
        // request cycle + 4 zero-wait word cycles + DONE: memready seen on the 5th edge
        n_chk++;
        if (memready !== 1'b1 || n !== 5) begin
            n_fail++;
            $display("FAIL read_latency: got rdy=%b after %0d edges, expected 1 after 5", memready, n);
        end
        n_chk++;
        if (addr_q.size() !== 4 || addr_q[0] !== 32'h1230 || addr_q[1] !== 32'h1234 || addr_q[2] !== 32'h1238 || addr_q[3] !== 32'h123C) begin
            n_fail++;
            $display("FAIL read_addrs: got %0d addrs first=%h last=%h, expected 1230..123C", addr_q.size(), addr_q[0], addr_q[addr_q.size()-1]);
        end
        n_chk++;
        if (memdata !== 128'h000000A0_000000A1_000000A2_000000A3) begin
            n_fail++;
            $display("FAIL read_memdata: got %h expected 000000A0000000A1000000A2000000A3", memdata);
        end
        step();
        n_chk++;
        if (memready !== 1'b0 || rdy_cnt - r0 !== 1) begin
            n_fail++;
            $display("FAIL read_ready_pulse: got rdy=%b pulses=%0d expected 0 and 1", memready, rdy_cnt - r0);
        end
    endtask

    task automatic test_write();
        int n;
        logic [127:0] line;
        line = memdata; ack_delay = 3; stab_err = 0;
        memwrite = 1'b1; a = 32'h0000_0044; wd = 32'hDEAD_BEEF;
        step();
        a = 32'h0000_0F00; wd = 32'h0;
        n_chk++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h44 || bus_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_bus: got req=%b we=%b addr=%h wd=%h expected 1 1 00000044 deadbeef", bus_req, bus_we, bus_addr, bus_wdata);
        end
        wait_ready(n);
        memwrite = 1'b0;
        // 3 wait cycles + ack cycle after entry, then DONE
        n_chk++;
        if (memready !== 1'b1 || n !== 4) begin
            n_fail++;
            $display("FAIL write_latency: got rdy=%b after %0d more edges, expected 1 after 4", memready, n);
        end
        n_chk++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL write_stable: got %0d bus changes while waiting, expected 0", stab_err);
        end
        n_chk++;
        if (memdata !== line) begin
            n_fail++;
            $display("FAIL write_memdata: got %h expected %h", memdata, line);
        end
        step();
        ack_delay = 0;
    endtask

    task automatic test_priority();
        int n;
        addr_q.delete(); rd_base = 32'hB0;
        memread = 1'b1; memwrite = 1'b1; a = 32'h0000_0080; wd = 32'h1234_5678;
        step();
        n_chk++;
        if (bus_we !== 1'b1 || bus_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL prio_write_first: got we=%b wd=%h expected 1 12345678", bus_we, bus_wdata);
        end
        wait_ready(n);
        memwrite = 1'b0;
        n_chk++;
        if (memready !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_write_ready: got %b within %0d edges, expected 1", memready, n);
        end
        step();
        step();
        n_chk++;
        if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL prio_read_next: got req=%b we=%b addr=%h expected 1 0 00000080", bus_req, bus_we, bus_addr);
        end
        wait_ready(n);
        memread = 1'b0;
        n_chk++;
        if (memready !== 1'b1 || memdata !== 128'h000000B0_000000B1_000000B2_000000B3) begin
            n_fail++;
            $display("FAIL prio_read_line: got rdy=%b data=%h expected 1 000000B0000000B1000000B2000000B3", memready, memdata);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int n;
        int r0;
        rd_base = 32'hC0; r0 = rdy_cnt;
        memread = 1'b1; a = 32'h0000_2000;
        step(); step(); step();
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({memready, bus_req, bus_we, bus_addr, bus_wdata} !== 67'd0 || memdata !== 128'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rdy=%b req=%b addr=%h data=%h expected all 0", memready, bus_req, bus_addr, memdata);
        end
        memread = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        n_chk++;
        if (rdy_cnt !== r0) begin
            n_fail++;
            $display("FAIL abort_no_ready: got %0d pulses expected 0", rdy_cnt - r0);
        end
        addr_q.delete(); rd_base = 32'hD0;
        memread = 1'b1; a = 32'h0000_3004;
        wait_ready(n);
        memread = 1'b0;
        n_chk++;
        if (addr_q.size() !== 4 || addr_q[0] !== 32'h3000 || addr_q[3] !== 32'h300C || memdata !== 128'h000000D0_000000D1_000000D2_000000D3) begin
            n_fail++;
            $display("FAIL abort_refill: got %0d addrs data=%h expected 3000..300C 000000D0000000D1000000D2000000D3", addr_q.size(), memdata);
        end
        step();
    endtask

    task automatic test_stray_and_addr_change();
        int n;
        int r0;
        logic [127:0] line;
        line = memdata; r0 = rdy_cnt;
        stray = 1'b1;
        step(); step(); step();
        n_chk++;
        if (bus_req !== 1'b0 || memready !== 1'b0 || rdy_cnt !== r0 || memdata !== line) begin
            n_fail++;
            $display("FAIL stray_ack: got req=%b rdy=%b pulses=%0d data=%h expected 0 0 0 %h", bus_req, memready, rdy_cnt - r0, memdata, line);
        end
        stray = 1'b0;
        step();
        addr_q.delete(); rd_base = 32'hE0;
        memread = 1'b1; a = 32'h0000_4000;
        step(); step();
        a = 32'hFFFF_FFF0;
        wait_ready(n);
        memread = 1'b0;
        n_chk++;
        if (addr_q.size() !== 4 || addr_q[0] !== 32'h4000 || addr_q[1] !== 32'h4004 || addr_q[2] !== 32'h4008 || addr_q[3] !== 32'h400C) begin
            n_fail++;
            $display("FAIL latched_addr: got %0d addrs last=%h expected 4000..400C", addr_q.size(), addr_q[addr_q.size()-1]);
        end
        n_chk++;
        if (memready !== 1'b1 || memdata !== 128'h000000E0_000000E1_000000E2_000000E3) begin
            n_fail++;
            $display("FAIL latched_line: got rdy=%b data=%h expected 1 000000E0000000E1000000E2000000E3", memready, memdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write();
        test_priority();
        test_reset_abort();
        test_stray_and_addr_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
